div_unit: RTL and testbench

Multicycle 32-bit integer divider for the MIPS datapath, implementing `div` and `divu`. It sits beside the multiplier and consumes the outputs of operand registers A (dividend) and B (divisor) under control of the UC. The UC starts an operation and stalls in a wait state until `Done`. The unit then returns the quotient on `Lo` and the remainder on `Hi`; these feed the register-bank write-data mux for `mflo`/`mfhi`. It uses a radix-2 restoring algorithm over the operand magnitudes, followed by a sign-fixup step.

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit and the multicycle divider.
interface div_unit_if;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Lo;
  logic [31:0] Hi;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  // Control unit side: issues operations and waits for Done.
  modport master (
    output Start, Signed, A, B,
    input  Lo, Hi, Busy, Done, DivZero
  );

  // Divider side.
  modport slave (
    input  Start, Signed, A, B,
    output Lo, Hi, Busy, Done, DivZero
  );
endinterface

// File: rtl/div_unit.sv
// Multicycle 32-bit divider for div/divu: radix-2 restoring division on the
// operand magnitudes, one quotient bit per cycle, then a sign-fixup pass.
// Quotient goes to Lo, remainder to Hi.
module div_unit (
  input  logic      Clk,
  input  logic      Reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  // The partial remainder is always below the divisor, so 32 stored bits
  // suffice; the 33rd bit only exists transiently in the shifted trial value.
  logic [31:0] rem;
  logic [31:0] quo;      // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] dvs;      // divisor magnitude
  logic        q_neg;
  logic        r_neg;
  logic        dz_pend;  // divide-by-zero in flight through FIX
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic        busy_r;
  logic        done_r;
  logic        dz_r;

  logic [32:0] shifted;
  logic [32:0] trial;

  // 32-bit two's complement negation, truncated (so -2^31 maps to itself).
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand; raw value for unsigned operations.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    sv = signed'(v);
    return (sgn && (sv < 0)) ? neg32(v) : v;
  endfunction

  assign bus.Lo      = lo_r;
  assign bus.Hi      = hi_r;
  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.DivZero = dz_r;

  // Trial subtraction for the current iteration: bit 32 set means it went negative.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
  end

  // Control FSM with the iteration datapath and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      dvs     <= 32'd0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_pend <= 1'b0;
      lo_r    <= 32'd0;
      hi_r    <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.Start) begin
            dz_r <= 1'b0;
            if (bus.B == 32'd0) begin
              // Skip the iterations; FIX only spends the cycle that keeps
              // Done one edge after the accept, Hi/Lo are left untouched.
              dz_pend <= 1'b1;
              state   <= FIX;
            end else begin
              rem    <= 32'd0;
              quo    <= mag32(bus.A, bus.Signed);
              dvs    <= mag32(bus.B, bus.Signed);
              q_neg  <= bus.Signed & (bus.A[31] ^ bus.B[31]);
              r_neg  <= bus.Signed & bus.A[31];
              cnt    <= 6'd32;
              busy_r <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt != 6'd0) begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
          end else begin
            // All 32 bits resolved: publish the sign-corrected results.
            lo_r  <= q_neg ? neg32(quo) : quo;
            hi_r  <= r_neg ? neg32(rem) : rem;
            state <= FIX;
          end
        end
        FIX: begin
          if (dz_pend) begin
            dz_r    <= 1'b1;
            dz_pend <= 1'b0;
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed operations with literal expectations plus a
// timeline model checked against every output on every cycle.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic chk_en = 1'b0;

  div_unit_if bus ();

  div_unit dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference result from plain arithmetic: {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    logic [31:0] qu, ru;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    qu = a / b;
    ru = a % b;
    return {ru, qu};
  endfunction

  // Timeline model: n counts edges since the accept edge.
  logic        m_active = 1'b0;
  int          m_n = 0;
  logic        m_dz_op = 1'b0;
  logic        m_dz = 1'b0;
  logic [31:0] m_lo = '0, m_hi = '0, m_res_lo = '0, m_res_hi = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_n = 0; m_dz_op = 1'b0; m_dz = 1'b0;
      m_lo = '0; m_hi = '0;
    end else if (!m_active) begin
      if (bus.Start) begin
        m_active = 1'b1;
        m_n      = 0;
        m_dz     = 1'b0;
        m_dz_op  = (bus.B == 32'd0);
        if (!m_dz_op) {m_res_hi, m_res_lo} = ref_div(bus.A, bus.B, bus.Signed);
      end
    end else begin
      m_n++;
      if (!m_dz_op && m_n == 33) begin
        m_lo = m_res_lo;
        m_hi = m_res_hi;
      end
      if (m_dz_op && m_n == 1) m_dz = 1'b1;
      if (m_n == (m_dz_op ? 2 : 35)) m_active = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc Busy", {31'd0, bus.Busy}, {31'd0, m_active && !m_dz_op && m_n < 34});
      chk("cyc Done", {31'd0, bus.Done}, {31'd0, m_active && m_n == (m_dz_op ? 1 : 34)});
      chk("cyc DivZero", {31'd0, bus.DivZero}, {31'd0, m_dz});
      chk("cyc Lo", bus.Lo, m_lo);
      chk("cyc Hi", bus.Hi, m_hi);
    end
  end

  // Issue one operation and check literal results, latency and Busy length.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input int exp_lat, input logic exp_dz, input logic poke);
    int lat;
    int busy_n;
    @(negedge clk);
    bus.Start = 1'b1; bus.A = a; bus.B = b; bus.Signed = s;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    busy_n = int'(bus.Busy);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke && lat == 10) begin
        bus.Start = 1'b1; bus.A = 32'd50; bus.B = 32'd3; bus.Signed = 1'b0;
      end
      if (poke && lat == 11) bus.Start = 1'b0;
      if (bus.Done) break;
      busy_n += int'(bus.Busy);
      if (lat > 60) begin
        chk({name, " timeout"}, 32'(lat), 32'(exp_lat));
        break;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy cycles"}, 32'(busy_n), exp_dz ? 32'd0 : 32'd34);
    chk({name, " Lo"}, bus.Lo, exp_lo);
    chk({name, " Hi"}, bus.Hi, exp_hi);
    chk({name, " DivZero"}, {31'd0, bus.DivZero}, {31'd0, exp_dz});
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] rr;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset Lo", bus.Lo, 32'd0);
    chk("reset Hi", bus.Hi, 32'd0);
    chk("reset Busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset Done", {31'd0, bus.Done}, 32'd0);
    chk("reset DivZero", {31'd0, bus.DivZero}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    do_op("u100/7", 32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002, 34, 1'b0, 1'b0);
    do_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 1'b0, 1'b0);
    do_op("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 34, 1'b0, 1'b0);
    do_op("s-7/-2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'h00000003, 32'hFFFFFFFF, 34, 1'b0, 1'b0);
    do_op("smin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 34, 1'b0, 1'b0);
    do_op("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 34, 1'b0, 1'b0);
    do_op("u5/9", 32'd5, 32'd9, 1'b0, 32'h0, 32'd5, 34, 1'b0, 1'b0);
    do_op("ubig/2", 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 34, 1'b0, 1'b0);

    do_op("u100/7b", 32'd100, 32'd7, 1'b0, 32'h0E, 32'h02, 34, 1'b0, 1'b0);
    do_op("divzero", 32'h1234, 32'd0, 1'b0, 32'h0E, 32'h02, 1, 1'b1, 1'b0);
    do_op("after dz", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 34, 1'b0, 1'b0);

    do_op("poke", 32'd100, 32'd7, 1'b0, 32'h0E, 32'h02, 34, 1'b0, 1'b1);

    // Abort a running division with an asynchronous reset.
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 32'd100; bus.B = 32'd7; bus.Signed = 1'b0;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort Busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort Done", {31'd0, bus.Done}, 32'd0);
    chk("abort Lo", bus.Lo, 32'd0);
    chk("abort Hi", bus.Hi, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op("post-reset", 32'd100, 32'd7, 1'b0, 32'h0E, 32'h02, 34, 1'b0, 1'b0);

    // A few pseudo-random operations, results from the reference arithmetic.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      rr = ref_div(ra, rb, rs);
      do_op("rand", ra, rb, rs, rr[31:0], rr[63:32], 34, 1'b0, 1'b0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
